// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 definitions: block geometry, the schedule FSM state
// encoding and the small sigma functions used by the message expansion.
// No ports (package).
package sha256_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 16;
    localparam int unsigned ROUNDS          = 64;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EMIT = 2'b10
    } state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] shr(input logic [31:0] x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
    endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// sha256_w_expand
// Combinational SHA-256 message expansion:
//   W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]  (mod 2^32)
// Ports:
//   w_m2_i   W[t-2]
//   w_m7_i   W[t-7]
//   w_m15_i  W[t-15]
//   w_m16_i  W[t-16]
//   w_o      W[t]
module sha256_w_expand
    import sha256_pkg::*;
(
    input  logic [31:0] w_m2_i,
    input  logic [31:0] w_m7_i,
    input  logic [31:0] w_m15_i,
    input  logic [31:0] w_m16_i,
    output logic [31:0] w_o
);

    always_comb begin
        w_o = sigma1(w_m2_i) + w_m7_i + sigma0(w_m15_i) + w_m16_i;
    end

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Captures a 16-word block from the packer stream into a circular buffer,
// then streams W[0..63] to the compression core, expanding in place.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   data_in      packer word
//   MP_dv_in     packer word valid (no backpressure)
//   w_out        schedule word W[t]
//   w_valid      w_out valid
//   w_ready      core accepts w_out this cycle
//   w_idx        index t of w_out
//   block_done   pulse on the W[63] transfer
//   overrun      pulse when MP_dv_in arrives during EMIT
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          SKIP_LEAD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  MP_dv_in,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [5:0]            w_idx,
    output logic                  block_done,
    output logic                  overrun
);

    state_e                state_q, state_d;
    logic [3:0]            load_cnt_q, load_cnt_d;
    logic [6:0]            t_q, t_d;
    logic [DATA_WIDTH-1:0] w_out_q, w_out_d;
    logic                  w_valid_q, w_valid_d;
    logic [5:0]            w_idx_q, w_idx_d;

    logic [DATA_WIDTH-1:0] wbuf_q [WORDS_PER_BLOCK];

    logic                  wr_en;
    logic [3:0]            wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    // Buffer slots of W[t-2], W[t-7], W[t-15] and W[t-16] (= slot of t itself).
    logic [3:0]            t_lo;
    logic [DATA_WIDTH-1:0] w_new;

    assign t_lo = t_q[3:0];

    sha256_w_expand u_expand (
        .w_m2_i  (wbuf_q[t_lo - 4'd2]),
        .w_m7_i  (wbuf_q[t_lo - 4'd7]),
        .w_m15_i (wbuf_q[t_lo - 4'd15]),
        .w_m16_i (wbuf_q[t_lo]),
        .w_o     (w_new)
    );

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        w_out_d    = w_out_q;
        w_valid_d  = w_valid_q;
        w_idx_d    = w_idx_q;
        wr_en      = 1'b0;
        wr_idx     = load_cnt_q;
        wr_data    = data_in;
        block_done = 1'b0;
        overrun    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (MP_dv_in) begin
                    state_d = LOAD;
                    if (SKIP_LEAD) begin
                        load_cnt_d = '0;
                    end else begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        load_cnt_d = 4'd1;
                    end
                end
            end
            LOAD: begin
                if (MP_dv_in) begin
                    wr_en      = 1'b1;
                    wr_idx     = load_cnt_q;
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'(WORDS_PER_BLOCK - 1)) begin
                        state_d = EMIT;
                        t_d     = '0;
                    end
                end
            end
            EMIT: begin
                overrun = MP_dv_in;
                if ((t_q < 7'(ROUNDS)) && (!w_valid_q || w_ready)) begin
                    if (t_q < 7'(WORDS_PER_BLOCK)) begin
                        w_out_d = wbuf_q[t_lo];
                    end else begin
                        // W[t] overwrites W[t-16], which is no longer needed.
                        w_out_d = w_new;
                        wr_en   = 1'b1;
                        wr_idx  = t_lo;
                        wr_data = w_new;
                    end
                    w_valid_d = 1'b1;
                    w_idx_d   = t_q[5:0];
                    t_d       = t_q + 7'd1;
                end else if ((t_q == 7'(ROUNDS)) && w_valid_q && w_ready) begin
                    w_valid_d  = 1'b0;
                    block_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            t_q        <= '0;
            w_out_q    <= '0;
            w_valid_q  <= 1'b0;
            w_idx_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            w_out_q    <= w_out_d;
            w_valid_q  <= w_valid_d;
            w_idx_q    <= w_idx_d;
        end
    end

    // Buffer is not reset: every slot is rewritten during LOAD before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            wbuf_q[wr_idx] <= wr_data;
        end
    end

    assign w_out   = w_out_q;
    assign w_valid = w_valid_q;
    assign w_idx   = w_idx_q;

endmodule
